// File: rtl/llsc_ctrl_pkg.sv
// ============================================================================
// llsc_ctrl_pkg : shared encodings and word-compare macro for the LL/SC block
// Revision      : 1.0  initial release
// ============================================================================
`ifndef LLSC_CTRL_DEFINES
`define LLSC_CTRL_DEFINES
`ifndef RstEnable
`define RstEnable 1'b0
`endif
`ifndef WriteEnable
`define WriteEnable 1'b1
`endif
`define LLSC_IDLE   1'b0
`define LLSC_LINKED 1'b1
`define LLSC_WORD_EQ(a, b) ((a[31:2]) == (b[31:2]))
`endif

`default_nettype none

package llsc_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = `LLSC_IDLE,
    ST_LINKED = `LLSC_LINKED
  } llsc_state_e;

endpackage

`default_nettype wire

// File: rtl/llsc_timeout_cnt.sv
// ============================================================================
// llsc_timeout_cnt : saturating link-inactivity counter with expire pulse
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module llsc_timeout_cnt #(
  parameter int TIMEOUT_W    = 8,
  parameter int LINK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic Rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (Rst_n == `RstEnable) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (LINK_TIMEOUT == 0) begin : g_no_timeout
      assign expire_o = 1'b0;
    end else begin : g_timeout
      localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(LINK_TIMEOUT - 1);
      assign expire_o = enable_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/llsc_ctrl.sv
// ============================================================================
// llsc_ctrl : LL/SC link-bit controller for the MEM stage
//             (snoop ports and snoop kill enabled by LLSC_SNOOP_EN)
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module llsc_ctrl
  import llsc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W    = 8,
  parameter int LINK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        ll_valid,
  input  logic        sc_valid,
  input  logic [31:0] mem_addr,
`ifdef LLSC_SNOOP_EN
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
`endif
  output logic        sc_ok,
  output logic        LLbit_o,
  output logic [31:0] link_addr_o
);

  llsc_state_e state_q;
  logic [31:0] link_addr_q;
  logic        ll_fire;
  logic        sc_fire;
  logic        snoop_kill;
  logic        sc_hit;
  logic        expire;
  logic        cnt_clr;
  logic        unused_addr_lsb;

  assign LLbit_o     = (state_q == ST_LINKED);
  assign link_addr_o = link_addr_q;

  // A simultaneous LL takes priority, so the SC is treated as absent.
  assign ll_fire = ll_valid & ~stall;
  assign sc_fire = sc_valid & ~stall & ~ll_fire;

`ifdef LLSC_SNOOP_EN
  assign snoop_kill      = snoop_valid & `LLSC_WORD_EQ(snoop_addr, link_addr_q);
  assign unused_addr_lsb = ^{mem_addr[1:0], snoop_addr[1:0]};
`else
  assign snoop_kill      = 1'b0;
  assign unused_addr_lsb = ^mem_addr[1:0];
`endif

  assign sc_hit = LLbit_o & `LLSC_WORD_EQ(mem_addr, link_addr_q) & ~snoop_kill;
  assign sc_ok  = sc_fire & ~flush & sc_hit;

  // Counter restarts on every LL and sits at zero whenever the link is down.
  assign cnt_clr = ~LLbit_o | flush | ll_fire | sc_fire | snoop_kill | expire;

  llsc_timeout_cnt #(
    .TIMEOUT_W    (TIMEOUT_W),
    .LINK_TIMEOUT (LINK_TIMEOUT)
  ) u_timeout_cnt (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .clear_i  (cnt_clr),
    .enable_i (LLbit_o),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (Rst_n == `RstEnable) begin
      state_q     <= ST_IDLE;
      link_addr_q <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else if (ll_fire == `WriteEnable) begin
      state_q     <= ST_LINKED;
      link_addr_q <= {mem_addr[31:2], 2'b00};
    end else if (sc_fire || snoop_kill || expire) begin
      state_q <= ST_IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_llsc_ctrl.sv
// ============================================================================
// tb_llsc_ctrl : directed vector bench for llsc_ctrl (LINK_TIMEOUT = 4)
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_llsc_ctrl;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        ll_valid = 1'b0;
  logic        sc_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        sc_ok;
  logic        LLbit_o;
  logic [31:0] link_addr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  llsc_ctrl #(
    .TIMEOUT_W    (8),
    .LINK_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .Rst_n       (Rst_n),
    .flush       (flush),
    .stall       (stall),
    .ll_valid    (ll_valid),
    .sc_valid    (sc_valid),
    .mem_addr    (mem_addr),
`ifdef LLSC_SNOOP_EN
    .snoop_valid (snoop_valid),
    .snoop_addr  (snoop_addr),
`endif
    .sc_ok       (sc_ok),
    .LLbit_o     (LLbit_o),
    .link_addr_o (link_addr_o)
  );

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic        ll;
    logic        sc;
    logic [31:0] addr;
    logic        ok;
    logic        llbit;
    logic [31:0] laddr;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic r, input logic f, input logic s, input logic l,
                     input logic c, input logic [31:0] a, input logic ok,
                     input logic lb, input logic [31:0] la);
    vecs[nvec] = '{r, f, s, l, c, a, ok, lb, la};
    nvec++;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle, check sc_ok mid-cycle, then the registered state after the edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    Rst_n    = v.rst_n;
    flush    = v.flush;
    stall    = v.stall;
    ll_valid = v.ll;
    sc_valid = v.sc;
    mem_addr = v.addr;
    #1;
    check("sc_ok", idx, {31'd0, sc_ok}, {31'd0, v.ok});
    @(posedge clk);
    #1;
    check("LLbit", idx, {31'd0, LLbit_o}, {31'd0, v.llbit});
    check("link_addr", idx, link_addr_o, v.laddr);
    snoop_valid = 1'b0;
  endtask

  initial begin
    // rst flush stall ll sc addr | ok llbit link_addr
    add(0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0000_0000);
    // basic success
    add(1, 0, 0, 1, 0, 32'h1000_0004, 0, 1, 32'h1000_0004);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'h1000_0004);
    add(1, 0, 0, 0, 1, 32'h1000_0006, 1, 0, 32'h1000_0004);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h1000_0004);
    // address miss
    add(1, 0, 0, 1, 0, 32'h2000_0000, 0, 1, 32'h2000_0000);
    add(1, 0, 0, 0, 1, 32'h2000_0004, 0, 0, 32'h2000_0000);
    // flush precedence
    add(1, 0, 0, 1, 0, 32'h1000_0008, 0, 1, 32'h1000_0008);
    add(1, 1, 0, 0, 1, 32'h1000_0008, 0, 0, 32'h1000_0008);
    add(1, 1, 0, 1, 0, 32'h4000_0000, 0, 0, 32'h1000_0008);
    add(1, 0, 0, 0, 1, 32'h1000_0008, 0, 0, 32'h1000_0008);
    // stall gating and illegal LL+SC
    add(1, 0, 1, 1, 0, 32'h5000_0000, 0, 0, 32'h1000_0008);
    add(1, 0, 0, 1, 0, 32'h5000_0001, 0, 1, 32'h5000_0000);
    add(1, 0, 1, 0, 1, 32'h5000_0000, 0, 1, 32'h5000_0000);
    add(1, 0, 0, 1, 1, 32'h6000_0000, 0, 1, 32'h6000_0000);
    add(1, 0, 0, 0, 1, 32'h6000_0000, 1, 0, 32'h6000_0000);
    // relink moves the address
    add(1, 0, 0, 1, 0, 32'h7000_0000, 0, 1, 32'h7000_0000);
    add(1, 0, 0, 1, 0, 32'h7000_0100, 0, 1, 32'h7000_0100);
    add(1, 0, 0, 0, 1, 32'h7000_0000, 0, 0, 32'h7000_0100);
    // reset mid-link, overriding an in-flight LL
    add(1, 0, 0, 1, 0, 32'h8000_0000, 0, 1, 32'h8000_0000);
    add(0, 0, 0, 1, 0, 32'h9000_0000, 0, 0, 32'h0000_0000);
    add(1, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 32'h0000_0000);
    // timeout: 3 idle cycles then SC succeeds
    add(1, 0, 0, 1, 0, 32'hA000_0000, 0, 1, 32'hA000_0000);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'hA000_0000);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'hA000_0000);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'hA000_0000);
    add(1, 0, 0, 0, 1, 32'hA000_0000, 1, 0, 32'hA000_0000);
    // timeout: 4 idle cycles clear the link, SC fails
    add(1, 0, 0, 1, 0, 32'hB000_0000, 0, 1, 32'hB000_0000);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'hB000_0000);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'hB000_0000);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'hB000_0000);
    add(1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'hB000_0000);
    add(1, 0, 0, 0, 1, 32'hB000_0000, 0, 0, 32'hB000_0000);
    // timeout still runs while stalled
    add(1, 0, 0, 1, 0, 32'hC000_0000, 0, 1, 32'hC000_0000);
    add(1, 0, 1, 0, 0, 32'h0000_0000, 0, 1, 32'hC000_0000);
    add(1, 0, 1, 0, 0, 32'h0000_0000, 0, 1, 32'hC000_0000);
    add(1, 0, 1, 0, 0, 32'h0000_0000, 0, 1, 32'hC000_0000);
    add(1, 0, 1, 0, 0, 32'h0000_0000, 0, 0, 32'hC000_0000);

    for (int i = 0; i < nvec; i++) begin
      apply(vecs[i], i);
    end

    // LL immediately followed by SC in the next cycle
    apply('{1, 0, 0, 1, 0, 32'hD000_0040, 0, 1, 32'hD000_0040}, 100);
    apply('{1, 0, 0, 0, 1, 32'hD000_0043, 1, 0, 32'hD000_0040}, 101);

`ifdef LLSC_SNOOP_EN
    // snoop to the linked word kills a coincident SC
    apply('{1, 0, 0, 1, 0, 32'h3000_0010, 0, 1, 32'h3000_0010}, 200);
    snoop_valid = 1'b1;
    snoop_addr  = 32'h3000_0013;
    apply('{1, 0, 0, 0, 1, 32'h3000_0010, 0, 0, 32'h3000_0010}, 201);
    // snoop to the neighbouring word leaves the link alone
    apply('{1, 0, 0, 1, 0, 32'h3000_0010, 0, 1, 32'h3000_0010}, 202);
    snoop_valid = 1'b1;
    snoop_addr  = 32'h3000_0014;
    apply('{1, 0, 0, 0, 1, 32'h3000_0010, 1, 0, 32'h3000_0010}, 203);
    // standalone snoop hit clears the link at the next edge
    apply('{1, 0, 0, 1, 0, 32'h3000_0010, 0, 1, 32'h3000_0010}, 204);
    snoop_valid = 1'b1;
    snoop_addr  = 32'h3000_0010;
    apply('{1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h3000_0010}, 205);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/llsc_ctrl.md
# llsc_ctrl

Load-linked/store-conditional controller for the MEM stage. It owns the link bit and the linked word address. It evaluates SC success in the same cycle the SC is presented, and it clears the link on flush, optional bus snoop hits and inactivity timeout. It sits beside the MEM stage: it replaces direct MEM-stage writes of the link bit with a sequenced, priority-resolved controller, and its `sc_ok` output gates the SC memory write and the SC result value.

## Interface
Parameters:
- `TIMEOUT_W`, default 8: width of the link inactivity counter.
- `LINK_TIMEOUT`, default 255: number of linked cycles before auto-clear; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `Rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  exception/ERET pipeline flush.
- `stall`  in  1  MEM stage stalled; `ll_valid`/`sc_valid` ignored while high.
- `ll_valid`  in  1  LL instruction valid in MEM.
- `sc_valid`  in  1  SC instruction valid in MEM.
- `mem_addr`  in  32  effective address of the MEM-stage access.
- `snoop_valid`  in  1  external master write observed (present only with `LLSC_SNOOP_EN`).
- `snoop_addr`  in  32  address of the external write (present only with `LLSC_SNOOP_EN`).
- `sc_ok`  out  1  combinational; 1 = SC succeeds, so perform the store and write 1 to rt.
- `LLbit_o`  out  1  registered link bit.
- `link_addr_o`  out  32  registered linked address, word aligned ([1:0]=0).

## Operation
- **States:** IDLE (`LLbit_o`=0) and LINKED (`LLbit_o`=1). `LLbit_o` is the state decode.
- **Address compare:** word granularity on [31:2].
- **`sc_hit`:** LINKED & (`mem_addr`[31:2] == `link_addr_o`[31:2]) & ~`snoop_kill`.
- **`snoop_kill`:** `snoop_valid` & (`snoop_addr`[31:2] == `link_addr_o`[31:2]). It is 0 without the macro.
- **`sc_ok`:** `sc_valid` & ~`stall` & ~`flush` & `sc_hit`.
- **Next-state priority, highest first:**
  1. `flush` → IDLE.
  2. LL (`ll_valid` & ~`stall`) → LINKED, `link_addr_o` ← {`mem_addr`[31:2],2'b00}, counter ← 0. Applies from either state, so a new LL relinks.
  3. SC (`sc_valid` & ~`stall`) → IDLE, whether it succeeds or fails.
  4. `snoop_kill` → IDLE.
  5. Timeout: counter == `LINK_TIMEOUT`-1 while LINKED → IDLE.
  6. Otherwise hold. The counter increments each LINKED cycle, saturates, and is held at 0 in IDLE.
- `ll_valid` and `sc_valid` high together is illegal. If it happens, LL wins and `sc_ok`=0.
- `link_addr_o` is written only by LL. It keeps its stale value in IDLE and is never cleared except by reset.
- **Reset** (`Rst_n`=0 at an edge): state IDLE, `LLbit_o`=0, `link_addr_o`=0, counter 0. Reset overrides all events, including an in-flight LL.

## Timing
- `LLbit_o` and `link_addr_o` update on the edge after the LL cycle. An SC in the very next cycle sees LINKED.
- `sc_ok` has zero latency: it is valid combinationally in the SC's MEM cycle, from registered state plus current inputs.
- A snoop in the same cycle as an SC to the same word makes the SC fail.
- `flush` in the same cycle as an SC forces `sc_ok`=0.
- A stall holds state. The counter still advances while stalled; a timeout during a stall clears the link.
- With `LINK_TIMEOUT`=N, the link clears on the N-th edge after the LL edge.

## Configuration
- **`LLSC_SNOOP_EN` defined:** `snoop_valid`/`snoop_addr` ports exist, and an external write to the linked word clears the link at the next edge and fails a same-cycle SC.
- **Undefined:** the ports are absent, `snoop_kill` is tied to 0, and only flush, SC, LL and timeout affect the link.

## Structure
- **Shared defines file:** state encodings (`LLSC_IDLE`, `LLSC_LINKED`) and the word-compare macro. Reuse the existing `RstEnable`/`WriteEnable` defines.
- **One sub-module, `llsc_timeout_cnt`:**
  - Parameterized saturating counter.
  - Inputs: clear, enable.
  - Output: expire pulse.
  - When `LINK_TIMEOUT`=0 it ties expire to 0.

## Test plan
- **Basic success:** LL @0x1000_0004, idle 1 cycle, SC @0x1000_0006 → `sc_ok`=1 in the SC cycle; `LLbit_o`=0 next cycle.
- **Address miss:** LL @0x2000_0000 then SC @0x2000_0004 → `sc_ok`=0, `LLbit_o`=0 afterwards.
- **Flush precedence:** LL, then `flush`=1 in the same cycle as SC → `sc_ok`=0. LL with `flush`=1 → `LLbit_o` stays 0 and `link_addr_o` is unchanged.
- **Timeout:** `LINK_TIMEOUT`=4. LL, wait 3 cycles then SC → success. Repeat with 4 cycles → `LLbit_o`=0 and SC fails.
- **Snoop (macro on):** LL @0x3000_0010, snoop @0x3000_0013 coincident with SC → `sc_ok`=0. Snoop @0x3000_0014 → SC succeeds.
- **Reset mid-link:** LL, then `Rst_n`=0 for 1 cycle → `LLbit_o`=0, `link_addr_o`=0, and a following SC fails.
